// File: rtl/program_loader_encoder_pkg.sv
// Shared types for the program loader: mnemonic codes, opcode/funct values, encode classes, FSM states.
// Mnemonic codes 26..31 are undefined and are rejected by the encoder.
package loader_pkg;

    typedef enum logic [4:0] {
        M_ADD   = 5'd0,  M_AND   = 5'd1,  M_NOR   = 5'd2,  M_OR    = 5'd3,
        M_SLT   = 5'd4,  M_SLL   = 5'd5,  M_SRL   = 5'd6,  M_SUB   = 5'd7,
        M_ADDI  = 5'd8,  M_BEQ   = 5'd9,  M_BNE   = 5'd10, M_J     = 5'd11,
        M_JAL   = 5'd12, M_LW    = 5'd13, M_SLTI  = 5'd14, M_SW    = 5'd15,
        M_MPP   = 5'd16, M_MPPI  = 5'd17, M_PPXL  = 5'd18, M_PTMU  = 5'd19,
        M_PTML  = 5'd20, M_PTMD  = 5'd21, M_PTMR  = 5'd22, M_PPXLC = 5'd23,
        M_PMPXL = 5'd24, M_JR    = 5'd25
    } mnem_t;

    localparam logic [5:0] OPC_RTYPE = 6'd0,  OPC_ADDI  = 6'd1,  OPC_BEQ   = 6'd3,  OPC_BNE   = 6'd4;
    localparam logic [5:0] OPC_J     = 6'd5,  OPC_JAL   = 6'd6,  OPC_LW    = 6'd7,  OPC_SLTI  = 6'd9;
    localparam logic [5:0] OPC_SW    = 6'd10, OPC_MPP   = 6'd12, OPC_MPPI  = 6'd13, OPC_PPXL  = 6'd14;
    localparam logic [5:0] OPC_PTMU  = 6'd15, OPC_PTML  = 6'd16, OPC_PTMD  = 6'd17, OPC_PTMR  = 6'd18;
    localparam logic [5:0] OPC_PPXLC = 6'd19, OPC_PMPXL = 6'd20, OPC_JR    = 6'd24;

    localparam logic [5:0] FUNCT_ADD = 6'd1, FUNCT_AND = 6'd2, FUNCT_NOR = 6'd3, FUNCT_OR  = 6'd4;
    localparam logic [5:0] FUNCT_SLT = 6'd5, FUNCT_SLL = 6'd6, FUNCT_SRL = 6'd7, FUNCT_SUB = 6'd8;

    typedef enum logic [2:0] {R_TYPE, SHIFT, I_TYPE, J_TYPE, JR_TYPE, ILLEGAL} enc_class_t;

    typedef enum logic [1:0] {IDLE, LOAD, FULL, DONE} state_t;

endpackage

// File: rtl/program_loader_encoder_if.sv
// Host-side instruction stream, session control/status and IMEM write port of the loader.
// master = host/loader driver, slave = program_loader_encoder.
interface program_loader_encoder_if #(parameter int ADDR_W = 10);
    import loader_pkg::*;

    logic              start;
    logic              finish;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        mnem;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [15:0]       imm16;
    logic [25:0]       target26;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   word_count;
    logic              busy;
    logic              done;
    logic              err_illegal;
    logic              err_full;

    modport master (
        output start, finish, in_valid, mnem, rs, rt, rd, shamt, imm16, target26,
        input  in_ready, imem_we, imem_addr, imem_wdata, word_count, busy, done, err_illegal, err_full
    );

    modport slave (
        input  start, finish, in_valid, mnem, rs, rt, rd, shamt, imm16, target26,
        output in_ready, imem_we, imem_addr, imem_wdata, word_count, busy, done, err_illegal, err_full
    );

endinterface

// File: rtl/program_loader_encoder_instr_encoder.sv
// Packs a symbolic instruction into a 32-bit word; purely combinational, flags undefined mnemonics.
// Fields unused by the instruction class are forced to zero.
module instr_encoder
    import loader_pkg::*;
(
    input  logic [4:0]  mnem_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  shamt_i,
    input  logic [15:0] imm16_i,
    input  logic [25:0] target26_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    enc_class_t cls;
    logic [5:0] opc;
    logic [5:0] funct;

    always_comb begin
        cls   = ILLEGAL;
        opc   = OPC_RTYPE;
        funct = '0;
        case (mnem_i)
            M_ADD:   begin cls = R_TYPE;  funct = FUNCT_ADD; end
            M_AND:   begin cls = R_TYPE;  funct = FUNCT_AND; end
            M_NOR:   begin cls = R_TYPE;  funct = FUNCT_NOR; end
            M_OR:    begin cls = R_TYPE;  funct = FUNCT_OR;  end
            M_SLT:   begin cls = R_TYPE;  funct = FUNCT_SLT; end
            M_SUB:   begin cls = R_TYPE;  funct = FUNCT_SUB; end
            M_SLL:   begin cls = SHIFT;   funct = FUNCT_SLL; end
            M_SRL:   begin cls = SHIFT;   funct = FUNCT_SRL; end
            M_ADDI:  begin cls = I_TYPE;  opc = OPC_ADDI;  end
            M_BEQ:   begin cls = I_TYPE;  opc = OPC_BEQ;   end
            M_BNE:   begin cls = I_TYPE;  opc = OPC_BNE;   end
            M_LW:    begin cls = I_TYPE;  opc = OPC_LW;    end
            M_SLTI:  begin cls = I_TYPE;  opc = OPC_SLTI;  end
            M_SW:    begin cls = I_TYPE;  opc = OPC_SW;    end
            M_MPP:   begin cls = I_TYPE;  opc = OPC_MPP;   end
            M_MPPI:  begin cls = I_TYPE;  opc = OPC_MPPI;  end
            M_PPXL:  begin cls = I_TYPE;  opc = OPC_PPXL;  end
            M_PTMU:  begin cls = I_TYPE;  opc = OPC_PTMU;  end
            M_PTML:  begin cls = I_TYPE;  opc = OPC_PTML;  end
            M_PTMD:  begin cls = I_TYPE;  opc = OPC_PTMD;  end
            M_PTMR:  begin cls = I_TYPE;  opc = OPC_PTMR;  end
            M_PPXLC: begin cls = I_TYPE;  opc = OPC_PPXLC; end
            M_PMPXL: begin cls = I_TYPE;  opc = OPC_PMPXL; end
            M_J:     begin cls = J_TYPE;  opc = OPC_J;     end
            M_JAL:   begin cls = J_TYPE;  opc = OPC_JAL;   end
            M_JR:    begin cls = JR_TYPE; opc = OPC_JR;    end
            default: cls = ILLEGAL;
        endcase
    end

    // Shifts take their source from rt, so rs is dropped rather than encoded.
    always_comb begin
        word_o = '0;
        case (cls)
            R_TYPE:  word_o = {OPC_RTYPE, rs_i, rt_i, rd_i, 5'd0, funct};
            SHIFT:   word_o = {OPC_RTYPE, 5'd0, rt_i, rd_i, shamt_i, funct};
            I_TYPE:  word_o = {opc, rs_i, rt_i, imm16_i};
            J_TYPE:  word_o = {opc, target26_i};
            JR_TYPE: word_o = {opc, rs_i, 21'd0};
            default: word_o = '0;
        endcase
    end

    assign illegal_o = (cls == ILLEGAL);

endmodule

// File: rtl/program_loader_encoder.sv
// Session FSM that encodes accepted instructions and writes them to IMEM one cycle after the handshake.
// in_ready is high only in LOAD below DEPTH words; 1 word/clk sustained, illegal words are dropped.
module program_loader_encoder
    import loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    program_loader_encoder_if.slave  bus
);

    localparam logic [ADDR_W-1:0] BASE_L  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_ill_q, err_ill_d;
    logic              err_full_q, err_full_d;

    logic              in_ready;
    logic              hs;
    logic [31:0]       enc_word;
    logic              enc_illegal;

    instr_encoder u_enc (
        .mnem_i     (bus.mnem),
        .rs_i       (bus.rs),
        .rt_i       (bus.rt),
        .rd_i       (bus.rd),
        .shamt_i    (bus.shamt),
        .imm16_i    (bus.imm16),
        .target26_i (bus.target26),
        .word_o     (enc_word),
        .illegal_o  (enc_illegal)
    );

    always_comb begin
        state_d     = state_q;
        next_addr_d = next_addr_q;
        count_d     = count_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        err_ill_d   = err_ill_q;
        err_full_d  = err_full_q;
        in_ready    = (state_q == LOAD) && (count_q < DEPTH_L);
        hs          = bus.in_valid && in_ready;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d     = LOAD;
                    next_addr_d = BASE_L;
                    count_d     = '0;
                    err_ill_d   = 1'b0;
                    err_full_d  = 1'b0;
                end
            end
            LOAD: begin
                if (hs && enc_illegal) begin
                    err_ill_d = 1'b1;
                end
                if (hs && !enc_illegal) begin
                    we_d        = 1'b1;
                    addr_d      = next_addr_q;
                    wdata_d     = enc_word;
                    next_addr_d = next_addr_q + 1'b1;
                    count_d     = count_q + 1'b1;
                    if ((count_q + 1'b1) == DEPTH_L) begin
                        state_d = FULL;
                    end
                end
                // finish wins over FULL; a same-cycle word still writes next cycle.
                if (bus.finish) begin
                    state_d = DONE;
                end
            end
            FULL: begin
                if (bus.in_valid) begin
                    err_full_d = 1'b1;
                end
                if (bus.finish) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            next_addr_q <= BASE_L;
            count_q     <= '0;
            we_q        <= 1'b0;
            addr_q      <= BASE_L;
            wdata_q     <= '0;
            err_ill_q   <= 1'b0;
            err_full_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            next_addr_q <= next_addr_d;
            count_q     <= count_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            err_ill_q   <= err_ill_d;
            err_full_q  <= err_full_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.imem_we     = we_q;
    assign bus.imem_addr   = addr_q;
    assign bus.imem_wdata  = wdata_q;
    assign bus.word_count  = count_q;
    assign bus.busy        = (state_q == LOAD);
    assign bus.done        = (state_q == DONE);
    assign bus.err_illegal = err_ill_q;
    assign bus.err_full    = err_full_q;

endmodule
